// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared memory port.
// Grants one requester at a time and drives the read/write strobes.
module mem_port_arbiter #(
   parameter int unsigned RD_LAT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } state_e;

   localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        last_q;
   logic        owner_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        rd_q;
   logic        wr_q;
   logic        rvalid0_q;
   logic        rvalid1_q;
   logic [31:0] rdata0_q;
   logic [31:0] rdata1_q;

   logic        win0;
   logic        win1;
   logic        can_gnt;
   logic        gnt0;
   logic        gnt1;
   logic        we_d;
   logic [31:0] addr_d;
   logic [31:0] wdata_d;

   // On contention the requester that did not win last time goes first.
   always_comb begin
      win0    = m0_req & (~m1_req | last_q);
      win1    = m1_req & (~m0_req | ~last_q);
      can_gnt = (state_q == IDLE) & ~reset;
      gnt0    = can_gnt & win0;
      gnt1    = can_gnt & win1;
      we_d    = gnt1 ? m1_we : m0_we;
      addr_d  = gnt1 ? m1_addr : m0_addr;
      wdata_d = gnt1 ? m1_wdata : m0_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         last_q    <= 1'b1;
         owner_q   <= 1'b0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= 32'd0;
         rdata1_q  <= 32'd0;
      end else begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (gnt0 | gnt1) begin
                  last_q  <= gnt1;
                  owner_q <= gnt1;
                  addr_q  <= addr_d;
                  if (we_d) begin
                     wdata_q <= wdata_d;
                     wr_q    <= 1'b1;
                     state_q <= WR;
                  end else begin
                     rd_q    <= 1'b1;
                     cnt_q   <= CNT_LOAD;
                     state_q <= RD;
                  end
               end
            end
            RD: begin
               if (cnt_q == 4'd0) begin
                  rd_q    <= 1'b0;
                  state_q <= IDLE;
                  if (owner_q) begin
                     rdata1_q  <= mem_read_data;
                     rvalid1_q <= 1'b1;
                  end else begin
                     rdata0_q  <= mem_read_data;
                     rvalid0_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            WR: begin
               wr_q    <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               rd_q    <= 1'b0;
               wr_q    <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign m0_gnt         = gnt0;
   assign m1_gnt         = gnt1;
   assign m0_rvalid      = rvalid0_q;
   assign m1_rvalid      = rvalid1_q;
   assign m0_rdata       = rdata0_q;
   assign m1_rdata       = rdata1_q;
   assign mem_addr       = addr_q;
   assign mem_write_data = wdata_q;
   assign mem_read       = rd_q;
   assign mem_write      = wr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic
// checked against a transaction-level schedule model.
module tb_mem_port_arbiter;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0;
   logic        m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m1_addr = '0, m1_wdata = '0;
   logic [31:0] mem_read_data = '0;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_write_data;
   logic        mem_read, mem_write;

   logic        l_req = 1'b0;
   logic [31:0] l_addr = '0, l_rdin = '0;
   logic        l_zero = 1'b0;
   logic [31:0] l_zero32 = '0;
   logic        l_gnt, l_rvalid, l_gnt1, l_rvalid1;
   logic [31:0] l_rdata, l_rdata1, l_maddr, l_mwd;
   logic        l_mrd, l_mwr;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
      .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
      .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_read_data(mem_read_data)
   );

   mem_port_arbiter #(.RD_LAT(1)) dut_l1 (
      .clk(clk), .reset(reset),
      .m0_req(l_req), .m0_we(l_zero), .m0_addr(l_addr),
      .m0_wdata(l_zero32), .m0_gnt(l_gnt), .m0_rvalid(l_rvalid),
      .m0_rdata(l_rdata),
      .m1_req(l_zero), .m1_we(l_zero), .m1_addr(l_zero32),
      .m1_wdata(l_zero32), .m1_gnt(l_gnt1), .m1_rvalid(l_rvalid1),
      .m1_rdata(l_rdata1),
      .mem_addr(l_maddr), .mem_write_data(l_mwd),
      .mem_read(l_mrd), .mem_write(l_mwr),
      .mem_read_data(l_rdin)
   );

   // staged stimulus, applied at the next falling edge
   logic        s_reset = 1'b1;
   logic        s_m0_req = 1'b0, s_m0_we = 1'b0;
   logic [31:0] s_m0_addr = '0, s_m0_wdata = '0;
   logic        s_m1_req = 1'b0, s_m1_we = 1'b0;
   logic [31:0] s_m1_addr = '0, s_m1_wdata = '0;
   logic [31:0] s_rdata = '0;
   logic        s_l_req = 1'b0;
   logic [31:0] s_l_addr = '0, s_l_rdin = '0;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: current transaction and its cycle schedule
   int          cyc = 0;
   bit          t_act = 0, t_we = 0, t_own = 0;
   int          t_start = 0;
   logic [31:0] t_addr = '0, t_wdata = '0;
   int          free_at = 0;
   bit          last = 1;
   logic [31:0] rd0 = '0, rd1 = '0, e_addr = '0, e_wd = '0;
   bit          rv_pend = 0, rv_own = 0;
   int          rv_cyc = 0;
   logic [31:0] rv_data = '0;
   int          glog[$];
   int          gcyc[$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      bit e_rd, e_wr, e_rv0, e_rv1, e_g0, e_g1, idle;
      @(negedge clk);
      reset = s_reset;
      m0_req = s_m0_req; m0_we = s_m0_we;
      m0_addr = s_m0_addr; m0_wdata = s_m0_wdata;
      m1_req = s_m1_req; m1_we = s_m1_we;
      m1_addr = s_m1_addr; m1_wdata = s_m1_wdata;
      mem_read_data = s_rdata;
      l_req = s_l_req; l_addr = s_l_addr; l_rdin = s_l_rdin;
      #1;
      e_rv0 = rv_pend && rv_cyc == cyc && !rv_own;
      e_rv1 = rv_pend && rv_cyc == cyc && rv_own;
      if (e_rv0) rd0 = rv_data;
      if (e_rv1) rd1 = rv_data;
      if (rv_pend && rv_cyc == cyc) rv_pend = 0;
      e_rd = t_act && !t_we && cyc > t_start && cyc <= t_start + LAT;
      e_wr = t_act && t_we && cyc == t_start + 1;
      idle = cyc >= free_at;
      e_g0 = 0;
      e_g1 = 0;
      if (!s_reset && idle) begin
         if (s_m0_req && s_m1_req) begin
            e_g0 = last;
            e_g1 = !last;
         end else begin
            e_g0 = s_m0_req;
            e_g1 = s_m1_req;
         end
      end
      chk("m0_gnt", 32'(m0_gnt), 32'(e_g0));
      chk("m1_gnt", 32'(m1_gnt), 32'(e_g1));
      chk("mem_read", 32'(mem_read), 32'(e_rd));
      chk("mem_write", 32'(mem_write), 32'(e_wr));
      chk("m0_rvalid", 32'(m0_rvalid), 32'(e_rv0));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(e_rv1));
      chk("m0_rdata", m0_rdata, rd0);
      chk("m1_rdata", m1_rdata, rd1);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_write_data", mem_write_data, e_wd);
      if (s_reset) begin
         t_act = 0; rv_pend = 0; last = 1;
         rd0 = '0; rd1 = '0; e_addr = '0; e_wd = '0;
         free_at = cyc + 1;
      end else begin
         if (e_rd && cyc == t_start + LAT) begin
            rv_pend = 1; rv_cyc = cyc + 1;
            rv_own = t_own; rv_data = s_rdata;
         end
         if (e_g0 || e_g1) begin
            t_act = 1; t_start = cyc; t_own = e_g1;
            t_we = e_g1 ? s_m1_we : s_m0_we;
            t_addr = e_g1 ? s_m1_addr : s_m0_addr;
            t_wdata = e_g1 ? s_m1_wdata : s_m0_wdata;
            e_addr = t_addr;
            if (t_we) e_wd = t_wdata;
            last = e_g1;
            free_at = cyc + (t_we ? 2 : LAT + 1);
            glog.push_back(e_g1 ? 1 : 0);
            gcyc.push_back(cyc);
         end
      end
      cyc++;
   endtask

   task automatic idle_reqs();
      s_m0_req = 0; s_m1_req = 0;
   endtask

   initial begin
      // reset
      repeat (3) step();
      s_reset = 0;

      // single read by m0
      s_m0_req = 1; s_m0_we = 0; s_m0_addr = 32'h10;
      s_rdata = 32'hDEAD_BEEF;
      step();
      chk("t1_gnt", 32'(m0_gnt), 32'd1);
      idle_reqs();
      repeat (3) step();
      chk("t1_addr", mem_addr, 32'h10);
      step();
      chk("t1_rvalid", 32'(m0_rvalid), 32'd1);
      chk("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
      chk("t1_m1rv", 32'(m1_rvalid), 32'd0);

      // single write by m1, then m0 read two cycles later
      s_m1_req = 1; s_m1_we = 1; s_m1_addr = 32'h20;
      s_m1_wdata = 32'h1234_5678;
      step();
      idle_reqs();
      step();
      chk("t2_wr", 32'(mem_write), 32'd1);
      chk("t2_wd", mem_write_data, 32'h1234_5678);
      s_m0_req = 1; s_m0_addr = 32'h44; s_rdata = 32'h0BAD_F00D;
      step();
      chk("t2_wr_off", 32'(mem_write), 32'd0);
      chk("t2_next_gnt", 32'(m0_gnt), 32'd1);
      idle_reqs();
      repeat (4) step();

      // contention from reset
      s_reset = 1;
      repeat (2) step();
      s_reset = 0;
      glog.delete(); gcyc.delete();
      s_m0_req = 1; s_m0_we = 0; s_m0_addr = 32'h100;
      s_m1_req = 1; s_m1_we = 0; s_m1_addr = 32'h200;
      for (int i = 0; i < 12; i++) begin
         s_rdata = $urandom();
         step();
      end
      idle_reqs();
      repeat (4) step();
      chk("t3_ngrants", 32'(glog.size()), 32'd3);
      if (glog.size() == 3) begin
         chk("t3_order0", 32'(glog[0]), 32'd0);
         chk("t3_order1", 32'(glog[1]), 32'd1);
         chk("t3_order2", 32'(glog[2]), 32'd0);
         chk("t3_space", 32'(gcyc[1] - gcyc[0]), 32'd4);
         chk("t3_space2", 32'(gcyc[2] - gcyc[1]), 32'd4);
      end

      // withdrawn m1 request during an m0 read
      s_m0_req = 1; s_m0_addr = 32'h300; s_rdata = 32'h5555_AAAA;
      step();
      s_m0_req = 0; s_m1_req = 1; s_m1_we = 1; s_m1_addr = 32'h400;
      repeat (2) step();
      s_m1_req = 0;
      repeat (3) step();
      s_m0_req = 1; s_m1_req = 1; s_m1_we = 0;
      step();
      chk("t4_last_kept", 32'(m1_gnt), 32'd1);
      idle_reqs();
      repeat (4) step();

      // reset in the middle of an m0 read
      s_m0_req = 1; s_m0_addr = 32'h500; s_rdata = 32'h7777_1111;
      step();
      idle_reqs();
      step();
      s_reset = 1;
      step();
      s_reset = 0;
      step();
      chk("t5_rd_off", 32'(mem_read), 32'd0);
      chk("t5_rdata0", m0_rdata, 32'd0);
      repeat (3) step();
      s_m0_req = 1; s_m0_addr = 32'h600;
      step();
      chk("t5_regnt", 32'(m0_gnt), 32'd1);
      idle_reqs();
      repeat (4) step();

      // RD_LAT = 1 instance
      s_l_req = 1; s_l_addr = 32'h40; s_l_rdin = 32'hCAFE_F00D;
      step();
      chk("t6_gnt", 32'(l_gnt), 32'd1);
      s_l_req = 0;
      step();
      chk("t6_rd1", 32'(l_mrd), 32'd1);
      chk("t6_addr", l_maddr, 32'h40);
      chk("t6_rv_early", 32'(l_rvalid), 32'd0);
      s_l_rdin = 32'h0;
      step();
      chk("t6_rd_off", 32'(l_mrd), 32'd0);
      chk("t6_rv", 32'(l_rvalid), 32'd1);
      chk("t6_rdata", l_rdata, 32'hCAFE_F00D);
      step();
      chk("t6_rv_pulse", 32'(l_rvalid), 32'd0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         s_reset = ($urandom_range(0, 299) == 0);
         s_m0_req = ($urandom_range(0, 2) != 0);
         s_m1_req = ($urandom_range(0, 2) != 0);
         s_m0_we = ($urandom_range(0, 1) == 1);
         s_m1_we = ($urandom_range(0, 1) == 1);
         s_m0_addr = $urandom();
         s_m1_addr = $urandom();
         s_m0_wdata = $urandom();
         s_m1_wdata = $urandom();
         s_rdata = $urandom();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
